ring_decoder: RTL and testbench
===============================

// Module: ring_decoder
// PURPOSE
//  Receive-side monitor for the one-hot ring counter bus. Samples the WIDTH-bit one-hot
//  state each clk, encodes it to a binary index, classifies every transition (step, restart,
//  wrap, hold), recovers the counter's advance input (ori_est) and counts completed laps.
//  Flags illegal codes and illegal sequences with sticky errors. Sits at the consumer end
//  of the ring-counter output.
// PARAMETERS
//  WIDTH  4  ring length = one-hot bus width (>=2); position k <=> bit k hot
//  LAPW   8  lap_cnt width
// PORTS
//  clk       in   1              rising-edge clock, single clock domain
//  rst       in   1              synchronous, active-high reset
//  ring_in   in   WIDTH          one-hot ring state, sampled every clk
//  clr_err   in   1              clears sticky illegal/seq_err
//  idx       out  $clog2(WIDTH)  binary position of last legal sample
//  onehot_ok out  1              last sample had exactly one bit set
//  step      out  1              pulse: transition k->k+1 (k<WIDTH-1)
//  restart   out  1              pulse: transition k->0, 0<k<WIDTH-1 (advance dropped)
//  wrap      out  1              pulse: transition WIDTH-1->0
//  ori_est   out  1              recovered advance input level
//  lap_cnt   out  LAPW           count of wrap events, modulo 2^LAPW
//  illegal   out  1              sticky: zero-hot or multi-hot code seen
//  seq_err   out  1              sticky: legal codes, illegal transition
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): all outputs 0, state ACQ, prev position cleared.
//  - All outputs registered; sample at edge n is reflected in outputs after edge n (1-cycle latency).
//  - step/restart/wrap are single-cycle pulses; at most one asserted per cycle.
//  - Legal transitions from position k: k<WIDTH-1 -> {k+1, 0}; WIDTH-1 -> {0} only.
//    0->0 is a legal hold (ori low); hold at k>0 is illegal (counter never holds there).
//  - FSM states (enum in package):
//    ACQ:   first sample after reset. Legal code -> capture as prev, update idx, go TRACK, no pulses.
//           Illegal code -> set illegal, go FAULT.
//    TRACK: legal code: classify prev->cur; k->k+1: step=1, ori_est<=1; k->0 (0<k<last):
//           restart=1, ori_est<=0; last->0: wrap=1, lap_cnt+=1, ori_est unchanged;
//           0->0: no pulse, ori_est<=0. Any other legal pair (skip, hold k>0, last->k>0): seq_err<=1,
//           no pulse, ori_est unchanged, cur becomes prev (resync), stay TRACK.
//           Illegal code: illegal<=1, onehot_ok<=0, idx holds, no pulse, go FAULT.
//    FAULT: wait for ring_in == position 0 (bit0 only); then prev<=0, idx<=0, onehot_ok<=1, go TRACK,
//           no pulse. Any other legal code does not exit FAULT; illegal codes keep illegal set.
//  - onehot_ok updated every cycle from current sample's validity (0 while FAULT sees non-pos0 codes
//    that are illegal, 1 for legal codes).
//  - lap_cnt wraps 2^LAPW-1 -> 0 silently; never cleared except by rst.
//  - clr_err=1 clears illegal and seq_err at the edge; if a new error is detected the same cycle,
//    the set wins (flag stays 1). clr_err has no effect on FSM state.
//  - rst mid-lap: everything returns to reset values at that edge; next sample handled as ACQ.
//  - idx width rule: $clog2(WIDTH); encoder output undefined codes never reach idx (held instead).
// STRUCTURE
//  - Package ring_pkg: rd_state_t enum {ACQ, TRACK, FAULT}; ring one-hot position constants
//    (S0..S3 for WIDTH=4 use); function onehot2idx; shared with the ring counter.
//  - Sub-module ring_onehot_check (combinational): ring_in -> {valid, idx}; valid = exactly one bit set.
//  - Top: FSM, prev-position register, classifier, ori_est, lap counter, sticky flags.
// TESTING (WIDTH=4, LAPW=8)
//  - Reset then 0001,0010,0100,1000,0001 -> step x3 on cycles 2-4, wrap on 5th, lap_cnt=1, ori_est=1.
//  - 0001,0010,0100,0001 -> step,step,restart; ori_est 1->0; lap_cnt unchanged.
//  - 0001,0000 -> illegal=1, onehot_ok=0, idx=0 held; then 0100 -> still FAULT; 0001 -> TRACK, idx=0.
//  - 0001,0010,0010 -> seq_err=1, no pulse; then 0100 -> step=1 (resynced on 0010).
//  - 256 full laps -> lap_cnt wraps to 0; clr_err together with 1100 -> illegal stays 1.
//  - rst asserted after 0100 mid-lap -> all outputs 0 next cycle; 0010 afterwards -> ACQ capture, no pulse.

Source files
------------

// File: rtl/ring_pkg.sv
// ---------------------------------------------------------------------------
// ring_pkg
//   Shared definitions for the one-hot ring counter and its receive-side
//   monitor (ring_decoder).
//   - rd_state_t : monitor FSM states
//   - S0..S3     : one-hot position codes for the common WIDTH=4 ring
//   - onehot2idx : binary index of the lowest set bit of a code
//                  (codes up to 32 bits wide)
// ---------------------------------------------------------------------------
package ring_pkg;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,  // first sample after reset, nothing to compare against
    TRACK = 2'd1,  // locked onto the ring, classifying every transition
    FAULT = 2'd2   // bad code seen, waiting for the ring to show position 0
  } rd_state_t;

  // Position constants for a 4-position ring: position k <=> bit k hot.
  localparam int unsigned RING4_W = 4;
  localparam logic [RING4_W-1:0] S0 = 4'b0001;
  localparam logic [RING4_W-1:0] S1 = 4'b0010;
  localparam logic [RING4_W-1:0] S2 = 4'b0100;
  localparam logic [RING4_W-1:0] S3 = 4'b1000;

  // Widest ring the helper below can encode.
  localparam int unsigned ONEHOT_MAX_W = 32;

  // Binary index of the lowest set bit. For a legal one-hot code this is the
  // ring position; for other codes the result is meaningless and callers must
  // qualify it with a validity check.
  function automatic int unsigned onehot2idx(input logic [ONEHOT_MAX_W-1:0] code);
    int unsigned pos;
    pos = 0;
    for (int i = ONEHOT_MAX_W - 1; i >= 0; i--) begin
      if (code[i]) pos = i;
    end
    return pos;
  endfunction

endpackage : ring_pkg

// File: rtl/ring_onehot_check.sv
// ---------------------------------------------------------------------------
// ring_onehot_check
//   Purely combinational one-hot checker / encoder for the ring bus.
//   Ports:
//     ring_in  in  WIDTH          sampled one-hot ring state
//     valid    out 1              exactly one bit of ring_in is set
//     idx      out $clog2(WIDTH)  binary position of the hot bit
//                                 (only meaningful when valid=1)
// ---------------------------------------------------------------------------
module ring_onehot_check
  import ring_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         ring_in,
  output logic                     valid,
  output logic [$clog2(WIDTH)-1:0] idx
);

  localparam int IW = $clog2(WIDTH);

  int unsigned hot_cnt;

  // NOTE: every variable written in always_comb gets a value on entry, so no
  // path leaves it unassigned and no latch can be inferred.
  always_comb begin
    hot_cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      hot_cnt = hot_cnt + 32'(ring_in[i]);
    end
    valid = (hot_cnt == 1);
    idx   = IW'(onehot2idx(ONEHOT_MAX_W'(ring_in)));
  end

endmodule : ring_onehot_check

// File: rtl/ring_decoder.sv
// ---------------------------------------------------------------------------
// ring_decoder
//   Receive-side monitor for a one-hot ring counter bus. Every clock it
//   samples the ring state, encodes it, classifies the transition from the
//   previous legal position, recovers the counter's advance input, counts
//   completed laps and raises sticky flags for bad codes / bad sequences.
//   All outputs are registered: a sample taken at edge n is visible after n.
//   Ports:
//     clk        in  1              rising-edge clock
//     rst        in  1              synchronous active-high reset
//     ring_in    in  WIDTH          one-hot ring state
//     clr_err    in  1              clears illegal / seq_err (a new error
//                                   detected in the same cycle wins)
//     idx        out $clog2(WIDTH)  position of the last legal sample
//     onehot_ok  out 1              last sample had exactly one bit set
//     step       out 1              pulse: k -> k+1
//     restart    out 1              pulse: k -> 0 for 0 < k < WIDTH-1
//     wrap       out 1              pulse: WIDTH-1 -> 0
//     ori_est    out 1              recovered advance input level
//     lap_cnt    out LAPW           wrap events, modulo 2^LAPW
//     illegal    out 1              sticky: zero-hot or multi-hot code seen
//     seq_err    out 1              sticky: legal codes, illegal transition
// ---------------------------------------------------------------------------
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LAPW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     onehot_ok,
  output logic                     step,
  output logic                     restart,
  output logic                     wrap,
  output logic                     ori_est,
  output logic [LAPW-1:0]          lap_cnt,
  output logic                     illegal,
  output logic                     seq_err
);

  localparam int             IW      = $clog2(WIDTH);
  localparam logic [IW-1:0]  POS_ZERO = '0;
  localparam logic [IW-1:0]  POS_LAST = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CODE_POS0 = WIDTH'(1);

  // -------------------------------------------------------------------------
  // Current sample: validity and encoded position
  // -------------------------------------------------------------------------
  logic          cur_valid;
  logic [IW-1:0] cur_idx;

  ring_onehot_check #(
    .WIDTH (WIDTH)
  ) u_check (
    .ring_in (ring_in),
    .valid   (cur_valid),
    .idx     (cur_idx)
  );

  // -------------------------------------------------------------------------
  // Transition classifier (prev -> cur), valid only for legal cur codes
  // -------------------------------------------------------------------------
  rd_state_t     state;
  logic [IW-1:0] prev;

  logic is_step;
  logic is_restart;
  logic is_wrap;
  logic is_hold;
  logic is_legal_tr;

  always_comb begin
    // The last position can only go back to 0, so exclude it from stepping
    // (prev+1 would otherwise alias to 0 for power-of-two rings).
    is_step     = (prev != POS_LAST) && (cur_idx == prev + IW'(1));
    is_restart  = (cur_idx == POS_ZERO) && (prev != POS_ZERO) && (prev != POS_LAST);
    is_wrap     = (cur_idx == POS_ZERO) && (prev == POS_LAST);
    // Holding is legal only at position 0 (advance input low).
    is_hold     = (cur_idx == POS_ZERO) && (prev == POS_ZERO);
    is_legal_tr = is_step || is_restart || is_wrap || is_hold;
  end

  // Error detections for this cycle; they override a same-cycle clr_err.
  logic set_illegal;
  logic set_seq_err;

  always_comb begin
    set_illegal = !cur_valid;
    set_seq_err = (state == TRACK) && cur_valid && !is_legal_tr;
  end

  // -------------------------------------------------------------------------
  // FSM, position tracking, pulses, ori_est, lap counter and sticky flags
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACQ;
      prev      <= POS_ZERO;
      idx       <= POS_ZERO;
      onehot_ok <= 1'b0;
      step      <= 1'b0;
      restart   <= 1'b0;
      wrap      <= 1'b0;
      ori_est   <= 1'b0;
      lap_cnt   <= '0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      // Pulses last one cycle unless re-asserted below.
      step      <= 1'b0;
      restart   <= 1'b0;
      wrap      <= 1'b0;
      onehot_ok <= cur_valid;

      illegal   <= (illegal && !clr_err) || set_illegal;
      seq_err   <= (seq_err && !clr_err) || set_seq_err;

      case (state)
        ACQ: begin
          if (cur_valid) begin
            prev  <= cur_idx;
            idx   <= cur_idx;
            state <= TRACK;
          end else begin
            state <= FAULT;
          end
        end

        TRACK: begin
          if (cur_valid) begin
            // Illegal sequences resync on the new position as well.
            prev <= cur_idx;
            idx  <= cur_idx;
            if (is_step) begin
              step    <= 1'b1;
              ori_est <= 1'b1;
            end else if (is_restart) begin
              restart <= 1'b1;
              ori_est <= 1'b0;
            end else if (is_wrap) begin
              // Advance level is ambiguous on a wrap; keep the last estimate.
              wrap    <= 1'b1;
              lap_cnt <= lap_cnt + LAPW'(1);
            end else if (is_hold) begin
              ori_est <= 1'b0;
            end
          end else begin
            // idx keeps the last legal position.
            state <= FAULT;
          end
        end

        FAULT: begin
          // Only position 0 is an unambiguous resync point.
          if (ring_in == CODE_POS0) begin
            prev  <= POS_ZERO;
            idx   <= POS_ZERO;
            state <= TRACK;
          end
        end

        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

endmodule : ring_decoder

// File: tb/tb_ring_decoder.sv
// ---------------------------------------------------------------------------
// tb_ring_decoder
//   Directed, table-driven bench for ring_decoder (WIDTH=4, LAPW=8).
//   Each row gives the inputs for one clock edge and the outputs expected
//   right after that edge.
// ---------------------------------------------------------------------------
module tb_ring_decoder;
  import ring_pkg::*;

  localparam int WIDTH = 4;
  localparam int LAPW  = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] ring_in;
  logic             clr_err;
  logic [1:0]       idx;
  logic             onehot_ok;
  logic             step;
  logic             restart;
  logic             wrap;
  logic             ori_est;
  logic [LAPW-1:0]  lap_cnt;
  logic             illegal;
  logic             seq_err;

  ring_decoder #(
    .WIDTH (WIDTH),
    .LAPW  (LAPW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ring_in   (ring_in),
    .clr_err   (clr_err),
    .idx       (idx),
    .onehot_ok (onehot_ok),
    .step      (step),
    .restart   (restart),
    .wrap      (wrap),
    .ori_est   (ori_est),
    .lap_cnt   (lap_cnt),
    .illegal   (illegal),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      idx;
    logic            ok;
    logic            step;
    logic            restart;
    logic            wrap;
    logic            ori;
    logic [LAPW-1:0] lap;
    logic            ill;
    logic            seq;
  } out_t;

  typedef struct {
    string            tag;
    logic             rst;
    logic             clr;
    logic [WIDTH-1:0] ring;
    out_t             exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t tbl1[$];
  vec_t tbl2[$];

  function automatic vec_t mk(input string tag, input logic r, input logic c,
                              input logic [WIDTH-1:0] ring, input logic [1:0] i,
                              input logic ok, input logic st, input logic rs,
                              input logic wr, input logic ori,
                              input logic [LAPW-1:0] lap, input logic ill,
                              input logic seq);
    vec_t v;
    v.tag  = tag;
    v.rst  = r;
    v.clr  = c;
    v.ring = ring;
    v.exp  = '{idx: i, ok: ok, step: st, restart: rs, wrap: wr, ori: ori,
               lap: lap, ill: ill, seq: seq};
    return v;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("idx=%0d ok=%0b step=%0b restart=%0b wrap=%0b ori=%0b lap=%0d illegal=%0b seq_err=%0b",
                     o.idx, o.ok, o.step, o.restart, o.wrap, o.ori, o.lap, o.ill, o.seq);
  endfunction

  task automatic check(input string tag, input out_t got, input out_t exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got {%s} expected {%s}", tag, fmt(got), fmt(exp));
    end
  endtask

  // Drive one row, clock it in, then sample just after the edge.
  task automatic apply(input vec_t v);
    out_t got;
    rst     = v.rst;
    clr_err = v.clr;
    ring_in = v.ring;
    @(posedge clk);
    #1;
    got = '{idx: idx, ok: onehot_ok, step: step, restart: restart, wrap: wrap,
            ori: ori_est, lap: lap_cnt, ill: illegal, seq: seq_err};
    check(v.tag, got, v.exp);
  endtask

  initial begin
    logic [LAPW-1:0] exp_lap;

    rst     = 1'b1;
    clr_err = 1'b0;
    ring_in = '0;

    //           tag            rst clr ring  idx ok st rs wr ori lap ill seq
    tbl1.push_back(mk("reset",     1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Full lap: ACQ capture, three steps, wrap.
    tbl1.push_back(mk("acq_s0",    0, 0, S0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl1.push_back(mk("step_s1",   0, 0, S1, 1, 1, 1, 0, 0, 1, 0, 0, 0));
    tbl1.push_back(mk("step_s2",   0, 0, S2, 2, 1, 1, 0, 0, 1, 0, 0, 0));
    tbl1.push_back(mk("step_s3",   0, 0, S3, 3, 1, 1, 0, 0, 1, 0, 0, 0));
    tbl1.push_back(mk("wrap_s0",   0, 0, S0, 0, 1, 0, 0, 1, 1, 1, 0, 0));
    // Hold at 0, two steps, restart from position 2.
    tbl1.push_back(mk("hold_s0",   0, 0, S0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl1.push_back(mk("step_s1b",  0, 0, S1, 1, 1, 1, 0, 0, 1, 1, 0, 0));
    tbl1.push_back(mk("step_s2b",  0, 0, S2, 2, 1, 1, 0, 0, 1, 1, 0, 0));
    tbl1.push_back(mk("restart",   0, 0, S0, 0, 1, 0, 1, 0, 0, 1, 0, 0));
    // Zero-hot code -> FAULT; non-position-0 legal code stays in FAULT.
    tbl1.push_back(mk("hold_s0b",  0, 0, S0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl1.push_back(mk("zero_hot",  0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl1.push_back(mk("fault_s2",  0, 0, S2, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl1.push_back(mk("fault_exit",0, 0, S0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl1.push_back(mk("clr_ill",   0, 1, S0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    // Hold at position 1 is a sequence error; tracking resyncs on it.
    tbl1.push_back(mk("step_s1c",  0, 0, S1, 1, 1, 1, 0, 0, 1, 1, 0, 0));
    tbl1.push_back(mk("hold_s1",   0, 0, S1, 1, 1, 0, 0, 0, 1, 1, 0, 1));
    tbl1.push_back(mk("resync_s2", 0, 0, S2, 2, 1, 1, 0, 0, 1, 1, 0, 1));
    tbl1.push_back(mk("step_s3c",  0, 0, S3, 3, 1, 1, 0, 0, 1, 1, 0, 1));
    // last->k>0 with clr_err in the same cycle: the new error wins.
    tbl1.push_back(mk("s3_to_s1",  0, 1, S1, 1, 1, 0, 0, 0, 1, 1, 0, 1));
    tbl1.push_back(mk("clr_seq",   0, 1, S2, 2, 1, 1, 0, 0, 1, 1, 0, 0));
    tbl1.push_back(mk("step_s3d",  0, 0, S3, 3, 1, 1, 0, 0, 1, 1, 0, 0));
    tbl1.push_back(mk("wrap2",     0, 0, S0, 0, 1, 0, 0, 1, 1, 2, 0, 0));

    foreach (tbl1[i]) apply(tbl1[i]);

    // 256 full laps: lap_cnt wraps through 255 -> 0 and ends back at 2.
    exp_lap = 8'd2;
    for (int lap = 0; lap < 256; lap++) begin
      apply(mk("lap_s1", 0, 0, S1, 1, 1, 1, 0, 0, 1, exp_lap, 0, 0));
      apply(mk("lap_s2", 0, 0, S2, 2, 1, 1, 0, 0, 1, exp_lap, 0, 0));
      apply(mk("lap_s3", 0, 0, S3, 3, 1, 1, 0, 0, 1, exp_lap, 0, 0));
      exp_lap = exp_lap + 8'd1;
      apply(mk(exp_lap == 8'd0 ? "lap_wrap_to_0" : "lap_wrap",
               0, 0, S0, 0, 1, 0, 0, 1, 1, exp_lap, 0, 0));
    end

    //           tag            rst clr ring  idx ok st rs wr ori lap ill seq
    // Multi-hot with clr_err: illegal stays set.
    tbl2.push_back(mk("clr_1100",  0, 1, 4'b1100, 0, 0, 0, 0, 0, 1, 2, 1, 0));
    tbl2.push_back(mk("exit_s0",   0, 0, S0, 0, 1, 0, 0, 0, 1, 2, 1, 0));
    tbl2.push_back(mk("ml_s1",     0, 0, S1, 1, 1, 1, 0, 0, 1, 2, 1, 0));
    tbl2.push_back(mk("ml_s2",     0, 0, S2, 2, 1, 1, 0, 0, 1, 2, 1, 0));
    // Reset mid-lap, then ACQ capture at position 1 with no pulse.
    tbl2.push_back(mk("rst_mid",   1, 0, S2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl2.push_back(mk("acq_s1",    0, 0, S1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl2.push_back(mk("acq_step",  0, 0, S2, 2, 1, 1, 0, 0, 1, 0, 0, 0));
    // Illegal code as the very first sample after reset.
    tbl2.push_back(mk("rst2",      1, 0, S1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl2.push_back(mk("acq_zero",  0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl2.push_back(mk("acq_s3_f",  0, 0, S3, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl2.push_back(mk("acq_exit",  0, 0, S0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl2.push_back(mk("acq_step2", 0, 0, S1, 1, 1, 1, 0, 0, 1, 0, 1, 0));

    foreach (tbl2[i]) apply(tbl2[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ring_decoder
